i2c_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one `i2c_master_top` instance between up to eight independent requesters. Typical requesters are the power-up register-table sequencer, runtime status pollers and host-side register access. It sits between those clients and the master's `i2c_read_req`/`i2c_write_req` handshake. For the whole transaction it latches the granted requester's device address, register address, write data and direction. It returns read data and the error flag to the granted requester only.

---
 rtl/i2c_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters.
// Optional transaction watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_rd,
  input  logic [8*NUM_REQ-1:0]    req_dev_addr,
  input  logic [16*NUM_REQ-1:0]   req_reg_addr,
  input  logic [8*NUM_REQ-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_error,
  output logic                    m_read_req,
  output logic                    m_write_req,
  input  logic                    m_read_req_ack,
  input  logic                    m_write_req_ack,
  output logic [7:0]              m_dev_addr,
  output logic [15:0]             m_reg_addr,
  output logic [7:0]              m_wdata,
  input  logic [7:0]              m_rdata,
  input  logic                    m_error,
  output logic                    m_abort,
  output logic                    busy,
  output logic [2:0]              grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 32'd0) begin : g_bad_cfg
    $error("i2c_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t               state_q;
  logic [2:0]           last_grant_q;
  logic [2:0]           grant_q;
  logic                 rd_q;
  logic                 m_read_req_q;
  logic                 m_write_req_q;
  logic [7:0]           m_dev_addr_q;
  logic [15:0]          m_reg_addr_q;
  logic [7:0]           m_wdata_q;
  logic [NUM_REQ-1:0]   req_ack_q;
  logic [7:0]           rsp_rdata_q;
  logic                 rsp_error_q;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0]          tmo_cnt_q;
  logic                 m_abort_q;
`endif

  logic                 win_found_d;
  logic [2:0]           win_idx_d;
  logic                 ack_hit;

  // Lowest rotation offset from last_grant wins, so iterate offsets downward
  // and let the last hit overwrite.
  always_comb begin
    int idx;
    idx         = 0;
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        win_found_d = 1'b1;
        win_idx_d   = 3'(idx);
      end
    end
  end

  assign ack_hit = rd_q ? m_read_req_ack : m_write_req_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 3'(NUM_REQ - 1);
      grant_q       <= '0;
      rd_q          <= 1'b0;
      m_read_req_q  <= 1'b0;
      m_write_req_q <= 1'b0;
      m_dev_addr_q  <= '0;
      m_reg_addr_q  <= '0;
      m_wdata_q     <= '0;
      req_ack_q     <= '0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      m_abort_q     <= 1'b0;
`endif
    end else begin
      req_ack_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      m_abort_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            grant_q       <= win_idx_d;
            last_grant_q  <= win_idx_d;
            rd_q          <= req_rd[win_idx_d];
            m_read_req_q  <= req_rd[win_idx_d];
            m_write_req_q <= ~req_rd[win_idx_d];
            m_dev_addr_q  <= req_dev_addr[8*win_idx_d +: 8];
            m_reg_addr_q  <= req_reg_addr[16*win_idx_d +: 16];
            m_wdata_q     <= req_wdata[8*win_idx_d +: 8];
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (ack_hit) begin
            m_read_req_q  <= 1'b0;
            m_write_req_q <= 1'b0;
            rsp_rdata_q   <= rd_q ? m_rdata : 8'h00;
            rsp_error_q   <= m_error;
            req_ack_q     <= NUM_REQ'(1) << grant_q;
            state_q       <= RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            m_read_req_q  <= 1'b0;
            m_write_req_q <= 1'b0;
            m_abort_q     <= 1'b1;
            rsp_rdata_q   <= 8'h00;
            rsp_error_q   <= 1'b1;
            req_ack_q     <= NUM_REQ'(1) << grant_q;
            state_q       <= RESP;
          end else begin
            tmo_cnt_q     <= tmo_cnt_q + 32'd1;
          end
`endif
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack     = req_ack_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign m_read_req  = m_read_req_q;
  assign m_write_req = m_write_req_q;
  assign m_dev_addr  = m_dev_addr_q;
  assign m_reg_addr  = m_reg_addr_q;
  assign m_wdata     = m_wdata_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign m_abort     = m_abort_q;
`else
  assign m_abort     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter; the timeout step runs only when
// I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_bus_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_rd, req_ack;
  logic [8*N-1:0] req_dev_addr, req_wdata;
  logic [16*N-1:0] req_reg_addr;
  logic [7:0]     rsp_rdata, m_dev_addr, m_wdata, m_rdata;
  logic [15:0]    m_reg_addr;
  logic           rsp_error, m_read_req, m_write_req, m_read_req_ack, m_write_req_ack;
  logic           m_error, m_abort, busy;
  logic [2:0]     grant_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_dev_addr(req_dev_addr),
    .req_reg_addr(req_reg_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .m_read_req(m_read_req), .m_write_req(m_write_req),
    .m_read_req_ack(m_read_req_ack), .m_write_req_ack(m_write_req_ack),
    .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_error(m_error), .m_abort(m_abort),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    int w;
    rst = 1'b1;
    req_valid = '0; req_rd = '0;
    req_dev_addr = {8'h33, 8'h22, 8'h78, 8'h50};
    req_reg_addr = {16'h4000, 16'h2000, 16'h3008, 16'h0010};
    req_wdata    = {8'h44, 8'h11, 8'h82, 8'h00};
    m_read_req_ack = 1'b0; m_write_req_ack = 1'b0; m_rdata = '0; m_error = 1'b0;
    step(); step();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_wreq", m_write_req, 0);
    chk("rst_rreq", m_read_req, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_dev", m_dev_addr, 0);
    chk("rst_abort", m_abort, 0);
    rst = 1'b0;
    step();

    // Single write from requester 1, master acks after 50 cycles
    req_valid = 4'b0010;
    step();
    chk("wr_grant", grant_id, 1);
    chk("wr_rreq", m_read_req, 0);
    chk("wr_dev", m_dev_addr, 8'h78);
    chk("wr_reg", m_reg_addr, 16'h3008);
    chk("wr_data", m_wdata, 8'h82);
    chk("wr_busy", busy, 1);
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_write_req) hi++;
      if (i < 49) step();
    end
    chk("wr_req_cycles", hi, 50);
    m_write_req_ack = 1'b1; m_error = 1'b0;
    step();
    m_write_req_ack = 1'b0;
    chk("wr_req_ack", req_ack, 4'b0010);
    chk("wr_rsp_err", rsp_error, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_req_drop", m_write_req, 0);
    req_valid = '0;
    step();
    chk("wr_ack_pulse", req_ack, 0);
    chk("wr_idle", busy, 0);

    // Read with error from requester 0; a write ack must be ignored
    req_valid = 4'b0001; req_rd = 4'b0001;
    step();
    chk("rd_grant", grant_id, 0);
    chk("rd_rreq", m_read_req, 1);
    chk("rd_wreq", m_write_req, 0);
    m_write_req_ack = 1'b1;
    step();
    m_write_req_ack = 1'b0;
    chk("rd_wrong_ack_req", m_read_req, 1);
    chk("rd_wrong_ack_ack", req_ack, 0);
    m_read_req_ack = 1'b1; m_rdata = 8'h5A; m_error = 1'b1;
    step();
    m_read_req_ack = 1'b0; m_rdata = 8'h00; m_error = 1'b0;
    chk("rd_req_ack", req_ack, 4'b0001);
    chk("rd_rdata", rsp_rdata, 8'h5A);
    chk("rd_err", rsp_error, 1);
    chk("rd_drop", m_read_req, 0);
    req_valid = '0; req_rd = '0;
    step();
    chk("rd_hold_dev", m_dev_addr, 8'h50);

    // Field stability: requester 2 changes wdata during ISSUE
    req_valid = 4'b0100;
    step();
    chk("fs_grant", grant_id, 2);
    chk("fs_wdata0", m_wdata, 8'h11);
    req_wdata[23:16] = 8'h22;
    step(); step();
    chk("fs_wdata1", m_wdata, 8'h11);
    m_write_req_ack = 1'b1;
    step();
    m_write_req_ack = 1'b0;
    chk("fs_req_ack", req_ack, 4'b0100);
    req_valid = '0;
    req_wdata[23:16] = 8'h11;
    step();

    // Round-robin with all requesters held valid from reset
    rst = 1'b1;
    req_valid = 4'b1111;
    step();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      w = 0;
      while (!(m_write_req || m_read_req) && w < 20) begin
        step();
        w++;
      end
      chk("rr_req_seen", m_write_req, 1);
      chk("rr_grant", grant_id, t % 4);
      if (t > 0) chk("rr_low_gap", (w >= 2), 1);
      step(); step();
      m_write_req_ack = 1'b1;
      step();
      m_write_req_ack = 1'b0;
      chk("rr_req_ack", req_ack, 32'(1) << (t % 4));
    end

    // Reset while a read is in ISSUE
    req_valid = 4'b0010; req_rd = 4'b1111;
    step(); step();
    chk("mr_grant", grant_id, 1);
    chk("mr_rreq", m_read_req, 1);
    rst = 1'b1;
    #1;
    chk("mr_rreq_rst", m_read_req, 0);
    chk("mr_busy_rst", busy, 0);
    chk("mr_grant_rst", grant_id, 0);
    chk("mr_dev_rst", m_dev_addr, 0);
    m_read_req_ack = 1'b1;
    step(); step();
    chk("mr_no_ack", req_ack, 0);
    m_read_req_ack = 1'b0;
    req_valid = 4'b0011;
    rst = 1'b0;
    step();
    chk("mr_first_grant", grant_id, 0);
    chk("mr_first_rreq", m_read_req, 1);
    m_read_req_ack = 1'b1; m_rdata = 8'hC3;
    step();
    m_read_req_ack = 1'b0;
    chk("mr_req_ack", req_ack, 4'b0001);
    chk("mr_rdata", rsp_rdata, 8'hC3);
    req_valid = '0; req_rd = '0;
    step(); step();

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: master never acks
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    hi = 0;
    while (m_write_req && hi < 300) begin
      hi++;
      step();
    end
    chk("to_cycles", hi, 100);
    chk("to_abort", m_abort, 1);
    chk("to_req_ack", req_ack, 4'b1000);
    chk("to_err", rsp_error, 1);
    chk("to_rdata", rsp_rdata, 0);
    step();
    chk("to_abort_pulse", m_abort, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
